// File: rtl/msf_time_loader.sv
// Loads decoded MSF hour/minute frames into a six-digit clock at the next minute mark,
// forwards second ticks as increment strobes and tracks whether minute marks keep arriving.
module msf_time_loader #(
  parameter int TIMEOUT = 120
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       minute_mark_i,
  input  logic       frame_valid_i,
  output logic       frame_ready_o,
  input  logic [1:0] frame_hour_tens_i,
  input  logic [3:0] frame_hour_units_i,
  input  logic [2:0] frame_min_tens_i,
  input  logic [3:0] frame_min_units_i,
  output logic       inc_o,
  output logic       load_o,
  output logic [1:0] ld_hour_tens_o,
  output logic [3:0] ld_hour_units_o,
  output logic [2:0] ld_min_tens_o,
  output logic [3:0] ld_min_units_o,
  output logic       synced_o,
  output logic       err_o,
  output logic [1:0] dbg_state_o,
  output logic [6:0] dbg_tick_cnt_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [6:0] TMO      = 7'(TIMEOUT);

  logic [1:0] state_q;
  logic [1:0] hold_ht_q;
  logic [3:0] hold_hu_q;
  logic [2:0] hold_mt_q;
  logic [3:0] hold_mu_q;
  logic       pending_q;
  logic [6:0] cnt_q;

  logic hours_ok;
  logic frame_ok;
  logic accept;
  logic take_frame;
  logic load_set;
  logic cnt_hits;

  // Handshake: a frame transfers on any posedge where frame_valid_i && frame_ready_o;
  // ready is a pure function of state and reset and never depends on valid.
  assign frame_ready_o = rst_ni && (state_q != ST_LOAD);
  assign accept        = frame_valid_i && frame_ready_o;

  assign hours_ok = (frame_hour_tens_i < 2'd2) ||
                    ((frame_hour_tens_i == 2'd2) && (frame_hour_units_i <= 4'd3));
  assign frame_ok = hours_ok && (frame_hour_units_i <= 4'd9) &&
                    (frame_min_tens_i <= 3'd5) && (frame_min_units_i <= 4'd9);

  assign take_frame = accept && frame_ok;
  assign load_set   = (state_q == ST_ARMED) && minute_mark_i;
  assign cnt_hits   = tick_i && !minute_mark_i && (cnt_q == TMO - 7'd1);

  assign dbg_state_o    = state_q;
  assign dbg_tick_cnt_o = cnt_q;

  // FSM, holding register and load outputs. The ld_* registers sample the holding
  // register before it is overwritten, so a frame arriving with the mark loads the old time.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      hold_ht_q       <= '0;
      hold_hu_q       <= '0;
      hold_mt_q       <= '0;
      hold_mu_q       <= '0;
      pending_q       <= 1'b0;
      ld_hour_tens_o  <= '0;
      ld_hour_units_o <= '0;
      ld_min_tens_o   <= '0;
      ld_min_units_o  <= '0;
      load_o          <= 1'b0;
      inc_o           <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      err_o  <= accept && !frame_ok;
      load_o <= load_set;
      inc_o  <= tick_i && !load_set;

      if (take_frame) begin
        hold_ht_q <= frame_hour_tens_i;
        hold_hu_q <= frame_hour_units_i;
        hold_mt_q <= frame_min_tens_i;
        hold_mu_q <= frame_min_units_i;
      end

      case (state_q)
        ST_IDLE: begin
          if (take_frame) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          if (minute_mark_i) begin
            ld_hour_tens_o  <= hold_ht_q;
            ld_hour_units_o <= hold_hu_q;
            ld_min_tens_o   <= hold_mt_q;
            ld_min_units_o  <= hold_mu_q;
            pending_q       <= take_frame;
            state_q         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q   <= pending_q ? ST_ARMED : ST_IDLE;
          pending_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  // Seconds since the last minute mark, saturating; losing the marks drops sync.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      synced_o <= 1'b0;
    end else begin
      if (minute_mark_i) begin
        cnt_q <= '0;
      end else if (tick_i && (cnt_q != TMO)) begin
        cnt_q <= cnt_q + 7'd1;
      end

      if (load_set) begin
        synced_o <= 1'b1;
      end else if (cnt_hits) begin
        synced_o <= 1'b0;
      end
    end
  end

endmodule
